// File: rtl/imem_arbiter_if.sv
// Bus bundle for imem_arbiter: fetch port, loader port and RAM port.
// slave = arbiter view, master = requesters/RAM view.
interface imem_arbiter_if #(
    parameter int unsigned AW = 5
);
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [31:0]   fetch_ins;
    logic          fetch_err;
    logic          load_req;
    logic [31:0]   load_addr;
    logic [31:0]   load_data;
    logic          load_done;
    logic          load_gnt;
    logic          booting;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, load_req, load_addr, load_data, load_done, mem_rdata,
        output fetch_gnt, fetch_valid, fetch_ins, fetch_err, load_gnt, booting,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, load_req, load_addr, load_data, load_done, mem_rdata,
        input  fetch_gnt, fetch_valid, fetch_ins, fetch_err, load_gnt, booting,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Instruction-RAM arbiter: boot FSM holds fetch off until load_done, then round-robin
// between fetch and loader. Optional macro IMEM_ARB_MISALIGN_CHK_EN enables misalign checks.
module imem_arbiter #(
    parameter int unsigned AW       = 5,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst,
    imem_arbiter_if.slave bus
);
    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0] state;
    logic [0:0] state_next;
    logic       last_load;
    logic       rd_pend;
    logic       rd_err;
    logic       fetch_mis;
    logic       load_mis;
    logic       unused_bits;

`ifdef IMEM_ARB_MISALIGN_CHK_EN
    assign fetch_mis = (bus.fetch_addr[1:0] != 2'b00);
    assign load_mis  = (bus.load_addr[1:0]  != 2'b00);
`else
    assign fetch_mis = 1'b0;
    assign load_mis  = 1'b0;
`endif

    assign unused_bits = ^{bus.fetch_addr[31:AW+2], bus.fetch_addr[1:0],
                           bus.load_addr[31:AW+2],  bus.load_addr[1:0]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_next;
    end

    // Next state and combinational grants; the older-granted side wins a conflict
    always_comb begin
        state_next    = state;
        bus.fetch_gnt = 1'b0;
        bus.load_gnt  = 1'b0;
        if (!rst) begin
            case (state)
                BOOT: begin
                    bus.load_gnt = bus.load_req;
                    if (bus.load_done) state_next = RUN;
                end
                RUN: begin
                    if (bus.fetch_req && bus.load_req) begin
                        bus.fetch_gnt = last_load;
                        bus.load_gnt  = !last_load;
                    end else begin
                        bus.fetch_gnt = bus.fetch_req;
                        bus.load_gnt  = bus.load_req;
                    end
                end
                default: state_next = BOOT;
            endcase
        end
    end

    // RAM drive; misaligned grants are consumed without touching the RAM
    always_comb begin
        bus.mem_en    = (bus.fetch_gnt & ~fetch_mis) | (bus.load_gnt & ~load_mis);
        bus.mem_we    = bus.load_gnt & ~load_mis;
        bus.mem_addr  = bus.load_gnt ? bus.load_addr[AW+1:2] : bus.fetch_addr[AW+1:2];
        bus.mem_wdata = bus.load_data;
    end

    // Round-robin pointer, two-stage read pipeline and boot flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_load       <= 1'b1;
            rd_pend         <= 1'b0;
            rd_err          <= 1'b0;
            bus.fetch_valid <= 1'b0;
            bus.fetch_err   <= 1'b0;
            bus.fetch_ins   <= 32'h0;
            bus.booting     <= 1'b1;
        end else begin
            bus.booting <= (state_next == BOOT);
            if (bus.fetch_gnt)     last_load <= 1'b0;
            else if (bus.load_gnt) last_load <= 1'b1;
            rd_pend         <= bus.fetch_gnt;
            rd_err          <= bus.fetch_gnt & fetch_mis;
            bus.fetch_valid <= rd_pend;
            bus.fetch_err   <= rd_pend & rd_err;
            if (rd_pend) bus.fetch_ins <= rd_err ? NOP_WORD : bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized scoreboard bench for imem_arbiter with a behavioural RAM and reference model.
module tb_imem_arbiter;
    localparam int unsigned AW = 5;
`ifdef IMEM_ARB_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct { logic [31:0] ins; logic err; int due; } exp_t;
    typedef struct { logic [31:0] a; logic [31:0] d; } ld_t;

    logic clk;
    logic rst;
    imem_arbiter_if #(.AW(AW)) bus ();
    imem_arbiter #(.AW(AW), .NOP_WORD(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    logic [31:0] ram [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    exp_t        eq [$];
    logic [31:0] fq [$];
    ld_t         lq [$];
    int          checks;
    int          errors;
    int          cyc;
    bit          f_pend, l_pend, m_boot, m_last_load;
    logic [31:0] f_addr, l_addr, l_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: write commits at the edge, read data valid the next cycle
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit mis(input logic [31:0] a);
        return MIS_EN && (a[1:0] != 2'b00);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    // Monitor: every fetch_valid pops one expectation; overdue entries are failures
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.fetch_valid) begin
                if (eq.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
                else begin
                    e = eq.pop_front();
                    check("fetch_ins", bus.fetch_ins, e.ins);
                    check("fetch_err", 32'(bus.fetch_err), 32'(e.err));
                    check("latency_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (eq.size() > 0 && eq[0].due <= cyc) begin
                e = eq.pop_front();
                check("missing_valid", 32'd0, 32'd1);
            end
        end
    end

    // One clock of stimulus plus reference-model update; entered and left at posedge+1
    task automatic step(input bit ldone);
        bit   eg_f, eg_l;
        exp_t e;
        ld_t  l;
        if (!f_pend && fq.size() > 0) begin f_addr = fq.pop_front(); f_pend = 1'b1; end
        if (!l_pend && lq.size() > 0) begin l = lq.pop_front(); l_addr = l.a; l_data = l.d; l_pend = 1'b1; end
        bus.fetch_req  = f_pend;
        bus.fetch_addr = f_addr;
        bus.load_req   = l_pend;
        bus.load_addr  = l_addr;
        bus.load_data  = l_data;
        bus.load_done  = ldone;
        @(negedge clk);
        if (m_boot) begin
            eg_f = 1'b0; eg_l = l_pend;
        end else if (f_pend && l_pend) begin
            eg_f = m_last_load; eg_l = !m_last_load;
        end else begin
            eg_f = f_pend; eg_l = l_pend;
        end
        check("fetch_gnt", 32'(bus.fetch_gnt), 32'(eg_f));
        check("load_gnt", 32'(bus.load_gnt), 32'(eg_l));
        check("booting", 32'(bus.booting), 32'(m_boot));
        check("mem_en", 32'(bus.mem_en), 32'((eg_f && !mis(f_addr)) || (eg_l && !mis(l_addr))));
        check("mem_we", 32'(bus.mem_we), 32'(eg_l && !mis(l_addr)));
        if (eg_l) begin
            if (!mis(l_addr)) ref_mem[widx(l_addr)] = l_data;
            m_last_load = 1'b1;
            l_pend = 1'b0;
        end
        if (eg_f) begin
            e.err = mis(f_addr);
            e.ins = e.err ? 32'h0000_0000 : ref_mem[widx(f_addr)];
            e.due = cyc + 2;
            eq.push_back(e);
            m_last_load = 1'b0;
            f_pend = 1'b0;
        end
        if (ldone && m_boot) m_boot = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_step();
        if (fq.size() == 0 && $urandom_range(0, 1) == 1) fq.push_back(32'($urandom_range(0, 255)));
        if (lq.size() == 0 && $urandom_range(0, 3) == 0) lq.push_back('{32'($urandom_range(0, 255)), $urandom});
        step($urandom_range(0, 15) == 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.fetch_req = 1'b0; bus.fetch_addr = 32'h0; bus.load_req = 1'b0;
        bus.load_addr = 32'h0; bus.load_data = 32'h0; bus.load_done = 1'b0;
        f_pend = 1'b0; l_pend = 1'b0; m_boot = 1'b1; m_last_load = 1'b1;
        f_addr = 32'h0; l_addr = 32'h0; l_data = 32'h0;
        checks = 0; errors = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Boot hold: fetch waits while loader idle
        fq.push_back(32'h0);
        repeat (10) step(1'b0);

        // Preload every word, last write to 0x4 coincides with load_done
        for (int i = 0; i < (1 << AW); i++) begin
            if (i != 1) begin
                lq.push_back('{32'(i * 4), $urandom});
                step(1'b0);
            end
        end
        lq.push_back('{32'h4, 32'h2002_0004});
        step(1'b1);
        fq.push_back(32'h4);
        repeat (4) step(1'b0);

        // Streaming
        fq.push_back(32'h0); fq.push_back(32'h4); fq.push_back(32'h8); fq.push_back(32'hC);
        repeat (6) step(1'b0);

        // Contention on one word
        for (int i = 0; i < 3; i++) begin
            fq.push_back(32'h10);
            lq.push_back('{32'h10, 32'hA5A5_0000 + 32'(i)});
        end
        repeat (8) step(1'b0);

        // Wrap
        fq.push_back(32'h80);
        repeat (4) step(1'b0);

        // Misaligned accesses
        fq.push_back(32'h6);
        lq.push_back('{32'h5, 32'hDEAD_BEEF});
        repeat (3) step(1'b0);
        fq.push_back(32'h4);
        repeat (4) step(1'b0);

        repeat (300) rand_step();
        repeat (8) step(1'b0);

        // Reset in the cycle after a fetch grant
        fq.push_back(32'h0);
        step(1'b0);
        rst = 1'b1;
        #1;
        check("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
        check("rst_fetch_ins", bus.fetch_ins, 32'h0);
        check("rst_fetch_err", 32'(bus.fetch_err), 32'd0);
        check("rst_booting", 32'(bus.booting), 32'd1);
        check("rst_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
        check("rst_load_gnt", 32'(bus.load_gnt), 32'd0);
        eq.delete();
        m_boot = 1'b1; m_last_load = 1'b1; f_pend = 1'b0; l_pend = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        fq.push_back(32'h8);
        repeat (3) step(1'b0);
        step(1'b1);
        repeat (100) rand_step();
        repeat (8) step(1'b0);
        check("drain_empty", 32'(eq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
